// File: rtl/csa_accum_seq.sv
// Sequenced multi-operand accumulator: folds a programmed number of operands into a
// carry-save (S, C) pair, then resolves the pair to binary by iterative carry propagation.
module csa_accum_seq #(
    parameter int W  = 4,
    parameter int CW = 4,
    parameter int AW = W + CW
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          start_i,
    input  logic [CW-1:0] num_ops_i,
    input  logic          in_valid_i,
    input  logic [W-1:0]  in_data_i,
    output logic          in_ready_o,
    output logic          out_valid_o,
    output logic [AW-1:0] out_sum_o,
    input  logic          out_ready_i,
    output logic          busy_o
);

    // state   | meaning
    // IDLE    | waiting for start; num_ops sampled here
    // ACCUM   | accepting operands, 3:2 compress each into S/C
    // RESOLVE | propagate carries until C is zero
    // DONE    | result presented until consumed
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ACCUM   = 2'd1;
    localparam logic [1:0] ST_RESOLVE = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] s_q, s_d;
    logic [AW-1:0] c_q, c_d;
    logic [CW-1:0] rem_q, rem_d;
    logic [AW-1:0] sum_q, sum_d;
    logic [AW-1:0] x_ext;
    logic          hs;

    assign x_ext = {{(AW-W){1'b0}}, in_data_i};
    assign hs    = (state_q == ST_ACCUM) && in_valid_i;

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        c_d     = c_q;
        rem_d   = rem_q;
        sum_d   = sum_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    if (num_ops_i != '0) begin
                        s_d     = '0;
                        c_d     = '0;
                        rem_d   = num_ops_i;
                        state_d = ST_ACCUM;
                    end else begin
                        sum_d   = '0;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_ACCUM: begin
                if (hs) begin
                    s_d   = s_q ^ c_q ^ x_ext;
                    c_d   = ((s_q & c_q) | (s_q & x_ext) | (c_q & x_ext)) << 1;
                    rem_d = rem_q - 1'b1;
                    if (rem_q == CW'(1)) begin
                        state_d = ST_RESOLVE;
                    end
                end
            end
            ST_RESOLVE: begin
                // Each pass pushes the lowest nonzero carry bit up at least one position,
                // so C empties within AW passes.
                if (c_q == '0) begin
                    sum_d   = s_q;
                    state_d = ST_DONE;
                end else begin
                    s_d = s_q ^ c_q;
                    c_d = (s_q & c_q) << 1;
                end
            end
            default: begin
                if (out_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            s_q     <= '0;
            c_q     <= '0;
            rem_q   <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            c_q     <= c_d;
            rem_q   <= rem_d;
            sum_q   <= sum_d;
        end
    end

    assign in_ready_o  = (state_q == ST_ACCUM);
    assign out_valid_o = (state_q == ST_DONE);
    assign busy_o      = (state_q != ST_IDLE);
    assign out_sum_o   = sum_q;

endmodule
